// File: rtl/shift_sequencer.sv
// Multi-cycle barrel-shift sequencer driving a one-position shifter.
// Define SHIFT_SEQ_ROTATE_EN to add the rot input (rotate-through-self).
module shifter (
    input  logic [7:0] A,
    input  logic       LR,
    input  logic       SI,
    output logic [7:0] Y,
    output logic       C
);
    always_comb begin
        if (LR) begin
            Y = {SI, A[7:1]};
            C = A[0];
        end else begin
            Y = {A[6:0], SI};
            C = A[7];
        end
    end
endmodule

module shift_sequencer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [7:0]       a,
    input  logic [CNT_W-1:0] count,
    input  logic             LA,
    input  logic             LR,
`ifdef SHIFT_SEQ_ROTATE_EN
    input  logic             rot,
`endif
    output logic [7:0]       y,
    output logic             C,
    output logic             N,
    output logic             V,
    output logic             Z,
    output logic             busy,
    output logic             done
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [7:0]       y_q, y_d;
    logic             c_q, c_d;
    logic             v_q, v_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             la_q, la_d;
    logic             lr_q, lr_d;
    logic             sign_q, sign_d;
    logic             rot_mode;
    logic             sh_si;
    logic [7:0]       sh_y;
    logic             sh_c;

`ifdef SHIFT_SEQ_ROTATE_EN
    logic rot_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rot_q <= 1'b0;
        end else if (state_q == IDLE && start) begin
            rot_q <= rot;
        end
    end

    assign rot_mode = rot_q;
`else
    assign rot_mode = 1'b0;
`endif

    // Arithmetic left fills with the operand's original sign bit.
    always_comb begin
        if (rot_mode) begin
            sh_si = lr_q ? y_q[0] : y_q[7];
        end else if (la_q) begin
            sh_si = lr_q ? y_q[7] : sign_q;
        end else begin
            sh_si = 1'b0;
        end
    end

    shifter u_shifter (
        .A  (y_q),
        .LR (lr_q),
        .SI (sh_si),
        .Y  (sh_y),
        .C  (sh_c)
    );

    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        c_d     = c_q;
        v_d     = v_q;
        rem_d   = rem_q;
        la_d    = la_q;
        lr_d    = lr_q;
        sign_d  = sign_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    y_d     = a;
                    rem_d   = count;
                    la_d    = LA;
                    lr_d    = LR;
                    sign_d  = a[7];
                    c_d     = 1'b0;
                    v_d     = 1'b0;
                    state_d = (count != '0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                y_d   = sh_y;
                c_d   = sh_c;
                v_d   = v_q | (la_q & ~lr_q & ~rot_mode & (y_q[7] ^ y_q[6]));
                rem_d = rem_q - CNT_W'(1);
                if (rem_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            y_q     <= 8'h00;
            c_q     <= 1'b0;
            v_q     <= 1'b0;
            rem_q   <= '0;
            la_q    <= 1'b0;
            lr_q    <= 1'b0;
            sign_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            c_q     <= c_d;
            v_q     <= v_d;
            rem_q   <= rem_d;
            la_q    <= la_d;
            lr_q    <= lr_d;
            sign_q  <= sign_d;
        end
    end

    assign y    = y_q;
    assign C    = c_q;
    assign V    = v_q;
    assign N    = y_q[7];
    assign Z    = (y_q == 8'h00);
    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
endmodule
